// File: rtl/frame_bank_writer.sv
// Write side of the ping-pong frame BRAM: fills the bank not being read with one raster frame,
// then swaps banks once the reader has released the other one.
module frame_bank_writer #(
  parameter int unsigned F_SIZE     = 307200,
  parameter int unsigned ADDR_FRAME = 19,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_IMG    = 10
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  wr_en_o,
  output logic                  wr_bank_o,
  output logic [ADDR_FRAME-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_bank_o,
  output logic                  swap_o,
  input  logic                  rd_done_i,
  output logic [3:0]            image_num_o,
  output logic                  resync_o
);

  localparam logic [ADDR_FRAME-1:0] LAST_ADDR = ADDR_FRAME'(F_SIZE - 1);
  localparam logic [3:0]            IMG_LAST  = 4'(NUM_IMG - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_RD,
    SWAP
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_FRAME-1:0]   addr;
  logic [ADDR_FRAME-1:0]   addr_next;
  logic [ADDR_FRAME-1:0]   idx;
  logic                    rd_busy;
  logic                    transfer;
  logic                    accept;
  logic                    resync_hit;
  logic                    last;

  assign transfer  = in_valid & in_ready;
  assign rd_bank_o = ~wr_bank_o;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // idx is the address the accepted pixel lands on; a mid-frame sof restarts it at 0.
  always_comb begin
    state_next = state;
    addr_next  = addr;
    idx        = addr;
    accept     = 1'b0;
    resync_hit = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (transfer && in_sof) begin
          accept = 1'b1;
          idx    = '0;
        end
      end
      FILL: begin
        if (transfer) begin
          accept = 1'b1;
          if (in_sof && (addr != '0)) begin
            resync_hit = 1'b1;
            idx        = '0;
          end
        end
      end
      WAIT_RD: begin
        if (!rd_busy) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        state_next = IDLE;
        addr_next  = '0;
      end
      default: begin
        state_next = IDLE;
        addr_next  = '0;
      end
    endcase
    if (accept) begin
      last = (idx == LAST_ADDR);
      if (last) begin
        addr_next  = idx;
        state_next = rd_busy ? WAIT_RD : SWAP;
      end else begin
        addr_next  = idx + 1'b1;
        state_next = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      addr        <= '0;
      in_ready    <= 1'b0;
      wr_en_o     <= 1'b0;
      wr_bank_o   <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      swap_o      <= 1'b0;
      resync_o    <= 1'b0;
      image_num_o <= '0;
      rd_busy     <= 1'b0;
    end else begin
      addr     <= addr_next;
      in_ready <= (state_next == IDLE) || (state_next == FILL);
      wr_en_o  <= accept;
      if (accept) begin
        wr_addr_o <= idx;
        wr_data_o <= in_pixel;
      end
      swap_o   <= (state_next == SWAP);
      resync_o <= resync_hit;
      // Bank toggles on leaving SWAP, so the final write of a frame still hits the old bank.
      if (state == SWAP) begin
        wr_bank_o   <= ~wr_bank_o;
        image_num_o <= (image_num_o == IMG_LAST) ? 4'd0 : image_num_o + 4'd1;
        rd_busy     <= 1'b1;
      end else if (rd_done_i) begin
        rd_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_bank_writer.sv
// Randomized bench for frame_bank_writer with a cycle-level reference model of frame filling,
// reader hand-off and bank swapping.
module tb_frame_bank_writer;
  localparam int unsigned FS = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NI = 10;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_pixel = '0;
  logic          rd_done_i = 1'b0;
  logic          in_ready;
  logic          wr_en_o;
  logic          wr_bank_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          rd_bank_o;
  logic          swap_o;
  logic [3:0]    image_num_o;
  logic          resync_o;

  frame_bank_writer #(
    .F_SIZE(FS),
    .ADDR_FRAME(AW),
    .DATA_WIDTH(DW),
    .NUM_IMG(NI)
  ) dut (
    .clk(clk),
    .arst(arst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sof(in_sof),
    .in_pixel(in_pixel),
    .wr_en_o(wr_en_o),
    .wr_bank_o(wr_bank_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_bank_o(rd_bank_o),
    .swap_o(swap_o),
    .rd_done_i(rd_done_i),
    .image_num_o(image_num_o),
    .resync_o(resync_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int obs_wr, obs_swap, obs_resync;

  // Reference model: expected outputs for the current cycle plus frame bookkeeping.
  bit m_ready, m_wr_en, m_swap, m_resync, m_bank, m_busy, m_waiting, m_active, last_xfer;
  int m_count, m_num, m_addr, m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ready = 0; m_wr_en = 0; m_swap = 0; m_resync = 0; m_bank = 0;
    m_busy = 0; m_waiting = 0; m_active = 0; m_count = 0; m_num = 0;
    m_addr = 0; m_data = 0; last_xfer = 0;
  endtask

  task automatic model_step();
    bit busy_before, swap_now;
    busy_before = m_busy;
    swap_now    = m_swap;
    last_xfer   = in_valid && m_ready;
    m_wr_en = 0; m_resync = 0; m_swap = 0;
    if (swap_now) begin
      m_bank = ~m_bank;
      m_num = (m_num + 1) % NI;
      m_count = 0;
      m_active = 0;
    end
    if (m_waiting && !busy_before) begin
      m_waiting = 0;
      m_swap = 1;
    end
    if (last_xfer && (in_sof || m_active)) begin
      if (in_sof) begin
        m_resync = m_active;
        m_count = 0;
        m_active = 1;
      end
      m_wr_en = 1;
      m_addr = m_count;
      m_data = int'(in_pixel);
      m_count++;
      if (m_count == FS) begin
        if (busy_before) m_waiting = 1;
        else m_swap = 1;
      end
    end
    if (swap_now) m_busy = 1;
    else if (rd_done_i) m_busy = 0;
    m_ready = !(m_swap || m_waiting);
  endtask

  task automatic compare_outputs();
    check("in_ready", in_ready, m_ready);
    check("wr_en", wr_en_o, m_wr_en);
    if (m_wr_en) begin
      check("wr_addr", wr_addr_o, m_addr);
      check("wr_data", wr_data_o, m_data);
      check("wr_bank_at_write", wr_bank_o, m_bank);
    end
    check("swap", swap_o, m_swap);
    check("resync", resync_o, m_resync);
    check("image_num", image_num_o, m_num);
    check("wr_bank", wr_bank_o, m_bank);
    check("rd_bank", rd_bank_o, !m_bank);
    if (wr_en_o) obs_wr++;
    if (swap_o) obs_swap++;
    if (resync_o) obs_resync++;
  endtask

  task automatic check_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_wr_bank", wr_bank_o, 0);
    check("rst_rd_bank", rd_bank_o, 1);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_swap", swap_o, 0);
    check("rst_image_num", image_num_o, 0);
    check("rst_resync", resync_o, 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_done();
    rd_done_i = 1'b1;
    cycle();
    rd_done_i = 1'b0;
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] pix);
    in_valid = 1'b1;
    in_sof = sof;
    in_pixel = pix;
    last_xfer = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (last_xfer) break;
    end
    if (!last_xfer) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic clear_obs();
    obs_wr = 0; obs_swap = 0; obs_resync = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_obs();
    #3 check_reset();
    @(negedge clk) arst = 1'b0;

    // T1: basic frame into bank 0
    idle(2);
    clear_obs();
    for (int p = 0; p < FS; p++) send(p == 0, DW'(p));
    idle(3);
    check("t1_writes", obs_wr, FS);
    check("t1_swaps", obs_swap, 1);
    check("t1_rd_bank", rd_bank_o, 0);
    check("t1_wr_bank", wr_bank_o, 1);
    check("t1_image_num", image_num_o, 1);

    // T2: reader still busy when the second frame completes
    clear_obs();
    for (int p = 0; p < FS; p++) send(p == 0, DW'($urandom));
    idle(6);
    check("t2_no_swap_while_busy", obs_swap, 0);
    check("t2_ready_low", in_ready, 0);
    pulse_done();
    idle(4);
    check("t2_writes", obs_wr, FS);
    check("t2_swaps", obs_swap, 1);
    check("t2_rd_bank", rd_bank_o, 1);
    check("t2_image_num", image_num_o, 2);

    // T3: garbage before sof, then a frame with bubbles; done coincides with the swap cycle
    pulse_done();
    clear_obs();
    for (int p = 0; p < 5; p++) send(0, DW'($urandom));
    check("t3_garbage_dropped", obs_wr, 0);
    for (int p = 0; p < FS; p++) begin
      idle($urandom_range(0, 3));
      send(p == 0, DW'($urandom));
    end
    check("t3_swap_now", swap_o, 1);
    pulse_done();
    idle(3);
    check("t3_writes", obs_wr, FS);
    check("t3_swaps", obs_swap, 1);

    // T4: mid-frame resync at addr 7; reader still busy from the same-cycle done
    clear_obs();
    for (int p = 0; p < 7; p++) send(p == 0, DW'($urandom));
    for (int p = 0; p < FS; p++) send(p == 0, DW'($urandom));
    idle(4);
    check("t4_resyncs", obs_resync, 1);
    check("t4_wait_for_reader", obs_swap, 0);
    pulse_done();
    idle(3);
    check("t4_swaps", obs_swap, 1);
    check("t4_writes", obs_wr, 7 + FS);

    // T5: async reset mid-frame discards the partial frame
    clear_obs();
    for (int p = 0; p < 9; p++) send(p == 0, DW'($urandom));
    #2 arst = 1'b1;
    #1 check_reset();
    model_reset();
    @(negedge clk) arst = 1'b0;
    check("t5_no_swap", obs_swap, 0);
    idle(2);
    clear_obs();
    for (int p = 0; p < FS; p++) send(p == 0, DW'($urandom));
    idle(3);
    check("t5_swaps", obs_swap, 1);
    check("t5_rd_bank", rd_bank_o, 0);
    check("t5_image_num", image_num_o, 1);

    // Random traffic: bubbles, occasional resyncs and reader releases; image_num wraps
    clear_obs();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sof    = m_active ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 1) == 1);
      in_pixel  = DW'($urandom);
      rd_done_i = ($urandom_range(0, 9) == 0);
      cycle();
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    rd_done_i = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
